// File: rtl/uart_tx_src_arb_if.sv
// ---------------------------------------------------------------------------
// uart_tx_src_arb_if
// Bus bundle between the byte sources, the source arbiter/FIFO and uart_tx.
//
// Signals:
//   src_data   [NUM_SRC*DATA_W] source i occupies bits [i*DATA_W +: DATA_W]
//   src_valid  [NUM_SRC]        source i offers a byte
//   src_ready  [NUM_SRC]        one-hot or zero grant back to the sources
//   grant_id   [clog2(NUM_SRC)] index of the current grant, 0 when none
//   tx_data    [DATA_W]         byte presented to uart_tx, held between loads
//   tx_start                    one-cycle transmit request
//   tx_busy                     uart_tx is shifting a frame
//   fifo_count [clog2(DEPTH)+1] occupied FIFO entries
//   fifo_full / fifo_empty      FIFO status flags
//
// Modports: master = source/transmitter side, slave = arbiter block.
// ---------------------------------------------------------------------------
interface uart_tx_src_arb_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 4
);
  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [SEL_W-1:0]          grant_id;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_start;
  logic                      tx_busy;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;

  modport master (
    output src_data, src_valid, tx_busy,
    input  src_ready, grant_id, tx_data, tx_start, fifo_count, fifo_full, fifo_empty
  );

  modport slave (
    input  src_data, src_valid, tx_busy,
    output src_ready, grant_id, tx_data, tx_start, fifo_count, fifo_full, fifo_empty
  );
endinterface

// File: rtl/uart_tx_src_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_src_arb
// Arbitrates NUM_SRC byte sources (valid/ready) into a DEPTH-entry FIFO and
// feeds uart_tx with a held tx_data byte plus a one-cycle tx_start pulse,
// paced by tx_busy.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_src_arb_if.slave (source handshake, tx side, FIFO status)
//
// Build option:
//   UART_TX_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                              undefined -> round-robin starting after the
//                                           most recently served source
// ---------------------------------------------------------------------------
module uart_tx_src_arb #(
  parameter int DATA_W  = 8,
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_src_arb_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_full, fifo_empty;
  logic [DATA_W-1:0]  tx_data_p0;
  logic               tx_start_p0;
  logic               grant_vld;
  logic [SEL_W-1:0]   grant;
  logic [NUM_SRC-1:0] ready;
  logic [DATA_W-1:0]  push_data;
  logic               push, pop;
  int                 base;

  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always begins at source 0.
  assign base = 0;
`else
  // Round-robin: the search begins just after the last source served.
  logic [SEL_W-1:0] rr_last;

  assign base = int'(rr_last) + 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= SEL_W'(NUM_SRC - 1);
    end else if (push) begin
      rr_last <= grant;
    end
  end
`endif

  // Grant the first valid source from the search origin. Only the registered
  // full flag blocks the grant, so a pop never frees a slot in the same cycle.
  // The grant is also suppressed while reset is held so src_ready reads zero.
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx       = '0;
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = SEL_W'((base + k) % NUM_SRC);
      if (!grant_vld && bus.src_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
    if (fifo_full || !rst_n) begin
      grant_vld = 1'b0;
      grant     = '0;
    end
  end

  always_comb begin
    ready     = '0;
    push_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_vld && (grant == SEL_W'(i))) begin
        ready[i]  = 1'b1;
        push_data = bus.src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign push = |(ready & bus.src_valid);

  // Output FSM: one pop per frame, then wait for uart_tx to go busy and idle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !bus.tx_busy) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FIFO storage carries data only and is not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Stage p0: FIFO control, FSM state and the registered tx outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_data_p0  <= '0;
      tx_start_p0 <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_start_p0 <= pop;
      if (pop) begin
        tx_data_p0 <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign bus.src_ready  = ready;
  assign bus.grant_id   = grant;
  assign bus.tx_data    = tx_data_p0;
  assign bus.tx_start   = tx_start_p0;
  assign bus.fifo_count = count;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_empty = fifo_empty;
endmodule

// File: doc/uart_tx_src_arb.md
Name: uart_tx_src_arb

Overview:
- Parametrised successor to the 2:1 tx-data select in the UART FPGA top.
- Takes NUM_SRC byte sources, each with a valid/ready handshake, and arbitrates among them round-robin.
- Buffers accepted bytes in a DEPTH-entry FIFO and drives the UART transmitter with a held tx_data word and a one-cycle tx_start pulse, paced by tx_busy.
- Sits between the switch/pushbutton/CPU data sources and uart_tx.

Parameters:
- DATA_W, 8: width of each byte/word.
- NUM_SRC, 4: number of input sources; must be >= 2.
- DEPTH, 4: FIFO entries; must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src_data  in  NUM_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
- src_valid  in  NUM_SRC  source i has a byte; must not depend on src_ready.
- src_ready  out  NUM_SRC  one-hot or zero; grant to source i.
- grant_id  out  $clog2(NUM_SRC)  index of the current grant; 0 when none.
- tx_data  out  DATA_W  byte presented to uart_tx; held between loads.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_busy  in  1  high while uart_tx is shifting a frame.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.
- fifo_full  out  1  fifo_count == DEPTH.
- fifo_empty  out  1  fifo_count == 0.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): tx_data=0, tx_start=0, fifo_count=0, fifo_empty=1, fifo_full=0, rd/wr pointers=0, rr_last=NUM_SRC-1, FSM=IDLE, src_ready=0. Reset mid-frame discards the FIFO and any pending start; no tx_start after reset until a new push.

Arbiter (combinational grant, registered priority state):
- When fifo_full=0, grant the first source with src_valid=1 searching rr_last+1, rr_last+2, … modulo NUM_SRC.
- src_ready[grant]=1, all others 0. When fifo_full=1 or no valid source, src_ready=0 and grant_id=0.
- A push occurs on the rising edge where src_valid[g] & src_ready[g]. On a push, rr_last <= g. Without a push, rr_last holds.
- src_ready is computed from registered fifo_full only; there is no same-cycle pop-to-push bypass when full.

FIFO:
- Push writes src_data slice g at wr_ptr; wr_ptr increments modulo DEPTH, wrapping naturally.
- Pop reads at rd_ptr; rd_ptr increments modulo DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pop never occurs when empty; push never occurs when full.

Output FSM:
- IDLE: if fifo_empty=0 and tx_busy=0, pop. tx_data <= head, tx_start <= 1, go to START.
- START: tx_start high for exactly this cycle, cleared at next edge. Go to WAIT_BUSY.
- WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: stay until tx_busy=0, then go to IDLE.
- tx_data changes only on a pop in IDLE and otherwise holds its value.

Latency:
- Byte accepted at edge E: it is in the FIFO from E. If the FSM is IDLE and tx_busy=0, tx_data is valid and tx_start=1 after edge E+1.
- Minimum spacing between tx_start pulses: 4 cycles plus the uart_tx frame duration.

Optional Feature:
- Macro UART_TX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_last is removed and the search always starts at source 0.
- Undefined: round-robin as specified above.
- Reset values and the FIFO/FSM behaviour are identical in both builds.

Test Plan:
- Reset check: assert rst_n=0 mid-WAIT_DONE with fifo_count=3 -> immediately tx_start=0, tx_data=0x00, fifo_count=0, fifo_empty=1, src_ready=0. After release with no valid sources, no tx_start.
- Single byte: src_valid=4'b0001, src_data[7:0]=0xA5, tx_busy=0 -> push at edge E, tx_data=0xA5 and tx_start=1 for exactly one cycle after edge E+1. Bench raises tx_busy for 10 cycles then drops it -> FSM returns to IDLE, tx_data stays 0xA5.
- Round-robin: all four sources valid continuously with bytes 0x10/0x11/0x12/0x13, tx_busy held 1 -> pushes accepted in order src0, src1, src2, src3. fifo_full=1 after 4 pushes, then src_ready=0. With UART_TX_ARB_FIXED_PRIO_EN, the FIFO fills with 0x10 four times.
- Full/wrap: fill 4, drain 2 via tx_busy handshakes, push 2 more (0x20, 0x21) -> transmitted order is 0x12, 0x13, 0x20, 0x21 across the pointer wrap. fifo_count tracks 4,3,2,3,4,3,2,1,0.
- Simultaneous push/pop: fifo_count=1, IDLE, tx_busy=0, src2 valid 0x7E in the same cycle -> pop and push on the same edge, fifo_count stays 1, and 0x7E is transmitted next.
- Backpressure: tx_busy stuck at 1 for 100 cycles -> no further tx_start, FSM stays in WAIT_DONE, sources stall once fifo_full=1, and no data is lost after tx_busy falls.
